tachometer_pulse_generator: RTL and testbench

Emulates the motor's 360-pulse/rev tachometer. It converts a commanded RPM into a 50 %-duty pulse train on `tachometer_pulse_out` whose long-run frequency is exact. The command passes through a slew-rate limiter so the emulated speed ramps the way a real DC motor does. The block is used for hardware-in-the-loop bring-up and closed-loop verification of the tachometer measurement path and the PID speed loop, with no physical motor attached.

---
 rtl/tach_gen_pkg.sv | 21 ++
 rtl/clk_enable.sv | 32 +++
 rtl/tachometer_pulse_generator.sv | 144 ++++++++++++++
 tb/tb_tachometer_pulse_generator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tach_gen_pkg.sv
// Shared types and constants for the tachometer pulse generator.
package tach_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int ACC_W       = 28;
  localparam int RPM_W       = 9;
  localparam int EDGE_W      = 16;
  localparam int DEFAULT_PPR = 360;
  localparam int INC_PER_RPM = DEFAULT_PPR / 30;

  // Toggles per second per RPM: 2 toggles/pulse * ppr/60 = ppr/30.
  function automatic int inc_per_rpm(input int ppr);
    return ppr / 30;
  endfunction

endpackage

// File: rtl/clk_enable.sv
// Single-cycle enable strobe every DIVISOR+1 clocks; first strobe DIVISOR+1 clocks after reset.
module clk_enable #(
  parameter int DIVISOR = 124_999
) (
  input  logic clk_in,
  input  logic reset_in,
  output logic enable_o
);

  localparam int CNT_W = (DIVISOR < 1) ? 1 : $clog2(DIVISOR + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign enable_o = (cnt_q == CNT_W'(DIVISOR));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (enable_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tachometer_pulse_generator.sv
// Emulated 50%-duty tachometer: slew-limited RPM drives a phase accumulator
// whose overflow toggles the pulse, giving an exact long-run frequency.
module tachometer_pulse_generator
  import tach_gen_pkg::*;
#(
  parameter int CLK_HZ         = 125_000_000,
  parameter int PULSES_PER_REV = 360,
  parameter int MAX_RPM        = 500,
  parameter int RAMP_DIVISOR   = 124_999,
  parameter int RAMP_STEP      = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              enable_in,
  input  logic [RPM_W-1:0]  target_rpm_in,
  input  logic              target_valid_in,
  output logic              tachometer_pulse_out,
  output logic [RPM_W-1:0]  current_rpm_out,
  output logic              at_target_out,
  output logic [EDGE_W-1:0] edge_count_out
);

  localparam int              INC_RPM   = inc_per_rpm(PULSES_PER_REV);
  localparam logic [RPM_W-1:0] MAX_RPM_V = RPM_W'(MAX_RPM);
  localparam logic [RPM_W-1:0] STEP_V    = RPM_W'(RAMP_STEP);
  localparam logic [ACC_W:0]   CLK_HZ_V  = (ACC_W+1)'(CLK_HZ);

  state_t             state_q, state_d;
  logic [RPM_W-1:0]   target_q, target_d;
  logic [RPM_W-1:0]   current_q, current_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               pulse_q, pulse_d;
  logic               at_target_q, at_target_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;

  logic               ramp_tick;
  logic [RPM_W-1:0]   eff_target;
  logic [RPM_W-1:0]   diff;
  logic [ACC_W-1:0]   inc;
  logic [ACC_W:0]     sum;

  clk_enable #(
    .DIVISOR (RAMP_DIVISOR)
  ) u_ramp_tick (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .enable_o (ramp_tick)
  );

  assign eff_target = enable_in ? target_q : '0;

  // Ramp reads the registered target, so a strobe on a tick cycle waits a tick.
  always_comb begin
    target_d = target_q;
    if (target_valid_in) begin
      target_d = (target_rpm_in > MAX_RPM_V) ? MAX_RPM_V : target_rpm_in;
    end

    diff      = '0;
    current_d = current_q;
    if (ramp_tick) begin
      if (current_q < eff_target) begin
        diff      = eff_target - current_q;
        current_d = current_q + ((diff > STEP_V) ? STEP_V : diff);
      end else if (current_q > eff_target) begin
        diff      = current_q - eff_target;
        current_d = current_q - ((diff > STEP_V) ? STEP_V : diff);
      end
    end

    at_target_d = (current_d == (enable_in ? target_d : '0));
  end

  assign inc = ACC_W'(current_q) * ACC_W'(INC_RPM);
  assign sum = {1'b0, acc_q} + {1'b0, inc};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pulse_d = pulse_q;

    case (state_q)
      IDLE: begin
        acc_d   = '0;
        pulse_d = 1'b0;
        if (eff_target != '0) begin
          state_d = RUN;
        end
      end
      RUN, STOP: begin
        if (sum >= CLK_HZ_V) begin
          acc_d   = ACC_W'(sum - CLK_HZ_V);
          pulse_d = ~pulse_q;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end

        if (state_q == RUN) begin
          if (eff_target == '0) begin
            state_d = STOP;
          end
        end else if (eff_target != '0) begin
          state_d = RUN;
        end else if (current_q == '0) begin
          // Park low so the next start begins with a clean rising edge.
          pulse_d = 1'b0;
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    edge_d = edge_q + EDGE_W'(pulse_d & ~pulse_q);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      target_q    <= '0;
      current_q   <= '0;
      acc_q       <= '0;
      pulse_q     <= 1'b0;
      at_target_q <= 1'b0;
      edge_q      <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      current_q   <= current_d;
      acc_q       <= acc_d;
      pulse_q     <= pulse_d;
      at_target_q <= at_target_d;
      edge_q      <= edge_d;
    end
  end

  assign tachometer_pulse_out = pulse_q;
  assign current_rpm_out      = current_q;
  assign at_target_out        = at_target_q;
  assign edge_count_out       = edge_q;

endmodule

// File: tb/tb_tachometer_pulse_generator.sv
// Directed bench for tachometer_pulse_generator with scaled-down clock and ramp parameters.
module tb_tachometer_pulse_generator;
  import tach_gen_pkg::*;

  localparam int CLK_HZ  = 12_000;
  localparam int PPR     = 360;
  localparam int MAX_RPM = 500;
  localparam int DIV     = 19;
  localparam int STEP    = 4;
  localparam int TP      = DIV + 1;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        enable_in;
  logic [8:0]  target_rpm_in;
  logic        target_valid_in;
  logic        tachometer_pulse_out;
  logic [8:0]  current_rpm_out;
  logic        at_target_out;
  logic [15:0] edge_count_out;

  tachometer_pulse_generator #(
    .CLK_HZ         (CLK_HZ),
    .PULSES_PER_REV (PPR),
    .MAX_RPM        (MAX_RPM),
    .RAMP_DIVISOR   (DIV),
    .RAMP_STEP      (STEP)
  ) dut (
    .clk_in               (clk_in),
    .reset_in             (reset_in),
    .enable_in            (enable_in),
    .target_rpm_in        (target_rpm_in),
    .target_valid_in      (target_valid_in),
    .tachometer_pulse_out (tachometer_pulse_out),
    .current_rpm_out      (current_rpm_out),
    .at_target_out        (at_target_out),
    .edge_count_out       (edge_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Clocks since reset release; ramp ticks land when this is a multiple of TP.
  int cyc;
  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  logic [8:0] last_rpm;
  int model_rpm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void push_ramp(input int from, input int to);
    int c;
    c = from;
    while (c != to) begin
      if (c < to) c += ((to - c) < STEP) ? (to - c) : STEP;
      else        c -= ((c - to) < STEP) ? (c - to) : STEP;
      exp_q.push_back(c);
    end
  endfunction

  task automatic run_ramp(input int max_pops, input int budget, output int first_cyc);
    int pops;
    int waited;
    int e;
    pops = 0;
    waited = 0;
    first_cyc = -1;
    while (exp_q.size() > 0 && pops < max_pops && waited < budget) begin
      @(negedge clk_in);
      waited++;
      if (current_rpm_out !== last_rpm) begin
        e = exp_q.pop_front();
        check("ramp_value", 32'(current_rpm_out), e);
        check("ramp_phase", cyc % TP, 0);
        if (first_cyc < 0) first_cyc = cyc;
        last_rpm  = current_rpm_out;
        model_rpm = e;
        pops++;
      end
    end
    if (pops < max_pops) check("ramp_drained", exp_q.size(), 0);
  endtask

  task automatic strobe(input logic [8:0] t);
    @(negedge clk_in);
    target_rpm_in   = t;
    target_valid_in = 1'b1;
    @(negedge clk_in);
    target_valid_in = 1'b0;
  endtask

  initial begin
    int first;
    int n;
    int hi;
    int lo;
    int strobe_cyc;
    logic prev;
    logic [15:0] e0;

    reset_in        = 1'b1;
    enable_in       = 1'b0;
    target_rpm_in   = '0;
    target_valid_in = 1'b0;
    last_rpm        = '0;
    model_rpm       = 0;

    #2;
    check("rst_pulse", 32'(tachometer_pulse_out), 0);
    check("rst_rpm", 32'(current_rpm_out), 0);
    check("rst_at_target", 32'(at_target_out), 0);
    check("rst_edges", 32'(edge_count_out), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;

    // Ramp 0 -> 100 in steps of 4, then 50% duty at 20-clock period.
    enable_in = 1'b1;
    strobe(9'd100);
    push_ramp(0, 100);
    run_ramp(1000, 30 * TP, first);
    @(negedge clk_in);
    check("ramp100_at_target", 32'(at_target_out), 1);
    check("ramp100_state", 32'(dut.state_q), 32'(RUN));

    n = 0;
    while (tachometer_pulse_out !== 1'b0 && n < 100) begin @(negedge clk_in); n++; end
    while (tachometer_pulse_out !== 1'b1 && n < 100) begin @(negedge clk_in); n++; end
    hi = 0;
    while (tachometer_pulse_out === 1'b1 && hi < 100) begin @(negedge clk_in); hi++; end
    lo = 0;
    while (tachometer_pulse_out === 1'b0 && lo < 100) begin @(negedge clk_in); lo++; end
    check("duty_high_clks", hi, 10);
    check("duty_low_clks", lo, 10);

    // Request above the clamp; ramp should stop at MAX_RPM.
    strobe(9'd511);
    check("clamp_not_at_target", 32'(at_target_out), 0);
    push_ramp(100, MAX_RPM);
    run_ramp(1000, 105 * TP, first);
    @(negedge clk_in);
    check("clamp_rpm", 32'(current_rpm_out), MAX_RPM);
    check("clamp_at_target", 32'(at_target_out), 1);

    // 500 RPM -> 3000 pulses/s at 12 kHz -> one pulse every 4 clocks.
    prev = tachometer_pulse_out;
    e0   = edge_count_out;
    n    = 0;
    repeat (1200) begin
      @(negedge clk_in);
      if (tachometer_pulse_out && !prev) n++;
      prev = tachometer_pulse_out;
    end
    check("edge_rate_300", 32'((n >= 299) && (n <= 301)), 1);
    check("edge_count_delta", 32'(16'(edge_count_out - e0)), n);

    // Reset while running at full speed.
    @(negedge clk_in);
    reset_in = 1'b1;
    #1;
    check("midrst_pulse", 32'(tachometer_pulse_out), 0);
    check("midrst_rpm", 32'(current_rpm_out), 0);
    check("midrst_at_target", 32'(at_target_out), 0);
    check("midrst_edges", 32'(edge_count_out), 0);
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk_in);
    reset_in  = 1'b0;
    last_rpm  = '0;
    model_rpm = 0;
    repeat (100) @(negedge clk_in);
    check("post_rst_edges", 32'(edge_count_out), 0);
    check("post_rst_rpm", 32'(current_rpm_out), 0);
    check("post_rst_state", 32'(dut.state_q), 32'(IDLE));

    // Strobe coinciding with a ramp tick: that tick still uses the old target.
    strobe(9'd20);
    push_ramp(0, 20);
    run_ramp(1000, 8 * TP, first);
    n = 0;
    while ((cyc % TP) != DIV && n < 2 * TP) begin @(negedge clk_in); n++; end
    target_rpm_in   = 9'd40;
    target_valid_in = 1'b1;
    strobe_cyc      = cyc + 1;
    @(negedge clk_in);
    target_valid_in = 1'b0;
    check("simul_hold", 32'(current_rpm_out), model_rpm);
    push_ramp(20, 40);
    run_ramp(1000, 8 * TP, first);
    check("simul_first_tick", first, strobe_cyc + TP);
    check("simul_final", 32'(current_rpm_out), 40);

    // Drop enable mid-ramp toward 200; ramp back to zero from wherever it is.
    strobe(9'd200);
    push_ramp(40, 200);
    run_ramp(10, 15 * TP, first);
    enable_in = 1'b0;
    exp_q.delete();
    push_ramp(model_rpm, 0);
    run_ramp(1000, 30 * TP, first);
    repeat (3) @(negedge clk_in);
    check("stop_rpm", 32'(current_rpm_out), 0);
    check("stop_pulse_low", 32'(tachometer_pulse_out), 0);
    check("stop_state", 32'(dut.state_q), 32'(IDLE));
    check("stop_at_target", 32'(at_target_out), 1);
    e0 = edge_count_out;
    repeat (200) @(negedge clk_in);
    check("stop_edges_frozen", 32'(edge_count_out), 32'(e0));
    check("stop_pulse_stays_low", 32'(tachometer_pulse_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
